// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : adder_pkg
//  Description : Shared FSM state type and parameter legality check for the
//                digit-serial adder.
//  Revision    : 1.0
// ============================================================================
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } adder_state_t;

    function automatic bit digit_width_ok(input int n, input int d);
        return (d >= 1) && (d <= n) && ((n % d) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_full_n.sv
`default_nettype none
// ============================================================================
//  Module      : adder_full_n
//  Description : Combinational n-bit ripple adder with carry in and carry out.
//  Revision    : 1.0
// ============================================================================
module adder_full_n #(
    parameter int n = 4
) (
    input  logic [n-1:0] X,
    input  logic [n-1:0] Y,
    input  logic         Cin,
    output logic [n-1:0] sum,
    output logic         carry
);

    logic [n:0] w_total;

    assign w_total = {1'b0, X} + {1'b0, Y} + {{n{1'b0}}, Cin};
    assign sum     = w_total[n-1:0];
    assign carry   = w_total[n];

endmodule
`default_nettype wire

// File: rtl/adder_digit_serial.sv
`default_nettype none
// ============================================================================
//  Module      : adder_digit_serial
//  Description : N-bit add/subtract processed D bits per cycle, LSB digit
//                first, with valid/ready handshakes, carry and overflow flags.
//  Revision    : 1.0
// ============================================================================
module adder_digit_serial
    import adder_pkg::*;
#(
    parameter int N = 32,
    parameter int D = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    input  logic         Cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         carry,
    output logic         overflow
);

    localparam int            STAGES = N / D;
    localparam int            KW     = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(STAGES - 1);

    generate
        if (!digit_width_ok(N, D)) begin : g_param_check
            $fatal(1, "adder_digit_serial: N must be a positive multiple of D");
        end
    endgenerate

    adder_state_t  state;
    adder_state_t  state_next;

    logic [N-1:0]  x_q;
    logic [N-1:0]  y_q;
    logic [N-1:0]  sum_q;
    logic          c_q;
    logic [KW-1:0] k;
    logic          carry_q;
    logic          ovf_q;

    logic [31:0]   w_base;
    logic [D-1:0]  w_s_digit;
    logic          w_c_digit;
    logic          w_last;

    assign w_base = 32'(k) * D;
    assign w_last = (k == LAST_K);

    adder_full_n #(.n(D)) u_digit_adder (
        .X     (x_q[w_base +: D]),
        .Y     (y_q[w_base +: D]),
        .Cin   (c_q),
        .sum   (w_s_digit),
        .carry (w_c_digit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = BUSY;
            BUSY:    if (w_last)    state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Subtraction is folded into the add path: X + ~Y + (1 ^ borrow_in).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            k       <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_q <= X;
                        y_q <= sub ? ~Y : Y;
                        c_q <= Cin ^ sub;
                        k   <= '0;
                    end
                end
                BUSY: begin
                    sum_q[w_base +: D] <= w_s_digit;
                    c_q                <= w_c_digit;
                    k                  <= k + 1'b1;
                    if (w_last) begin
                        carry_q <= w_c_digit;
                        ovf_q   <= (x_q[N-1] == y_q[N-1]) && (w_s_digit[D-1] != x_q[N-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_digit_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_digit_serial
//  Description : Self-checking bench: directed N=8/D=4 vectors with a result
//                scoreboard, plus random sweeps over several (N, D) pairs.
//  Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_adder_digit_serial;

    localparam int N = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rst_sw_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] X;
    logic [N-1:0] Y;
    logic         Cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         carry;
    logic         overflow;

    always #5 clk = ~clk;

    adder_digit_serial #(.N(N), .D(D)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .Y         (Y),
        .Cin       (Cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry),
        .overflow  (overflow)
    );

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic       cin;
        logic       sub;
        logic [7:0] s;
        logic       c;
        logic       v;
    } vec_t;

    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       v;
    } exp_t;

    int   total      = 0;
    int   bad        = 0;
    int   results    = 0;
    int   cyc        = 0;
    int   sweep_done = 0;
    exp_t sb[$];
    int   pop_cyc[$];
    exp_t m_e;
    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            check("sb_nonempty", 64'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                m_e = sb.pop_front();
                check("res_sum",      sum,      m_e.s);
                check("res_carry",    carry,    m_e.c);
                check("res_overflow", overflow, m_e.v);
            end
            results++;
            pop_cyc.push_back(cyc);
        end
    end

    task automatic send(input vec_t v);
        bit ok = 1'b0;
        in_valid = 1'b1;
        X = v.x; Y = v.y; Cin = v.cin; sub = v.sub;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
        end
        check("accept", 64'(ok), 1);
        if (ok) sb.push_back('{v.s, v.c, v.v});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int target, input string name);
        int n = 0;
        while (results < target && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 64'(results), 64'(target));
    endtask

    initial begin
        int rb;
        int n;
        int s0;

        vecs[0]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[2]  = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[3]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[4]  = '{8'h10, 8'h00, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0};
        vecs[5]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[6]  = '{8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[7]  = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[8]  = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
        vecs[9]  = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[10] = '{8'hFF, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};

        rst_n = 1'b0; rst_sw_n = 1'b0;
        in_valid = 1'b0; X = '0; Y = '0; Cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum",       sum,       0);
        check("rst_carry",     carry,     0);
        check("rst_overflow",  overflow,  0);
        @(negedge clk);
        rst_n = 1'b1; rst_sw_n = 1'b1;
        @(posedge clk); #1;

        // Latency: accept on E0, out_valid visible after E2
        send(vecs[0]);
        check("lat_e0", out_valid, 0);
        @(posedge clk); #1;
        check("lat_e1", out_valid, 0);
        @(posedge clk); #1;
        check("lat_e2", out_valid, 1);

        for (int i = 1; i < 11; i++) send(vecs[i]);
        wait_results(11, "table_results");

        // Abort an operation with reset in the middle of BUSY
        in_valid = 1'b1; X = 8'h12; Y = 8'h34; Cin = 1'b0; sub = 1'b0;
        @(negedge clk);
        check("abort_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready2", in_ready,  1);
        check("abort_sum",       sum,       0);
        check("abort_carry",     carry,     0);
        check("abort_overflow",  overflow,  0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("abort_no_result", 64'(results), 11);
        check("abort_idle",      out_valid,    0);

        // Backpressure in DONE while in_valid is pulsed
        out_ready = 1'b0;
        send('{8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0});
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_reach_done", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            X = 8'(i * 37 + 1);
            Y = 8'(i * 11 + 3);
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready",  in_ready,  0);
            check("bp_sum",       sum,       8'h4B);
            check("bp_carry",     carry,     0);
            check("bp_overflow",  overflow,  0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rb = results;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_one_handshake", 64'(results), 64'(rb + 1));
        check("bp_ready_after",   in_ready,     1);
        repeat (6) @(posedge clk);
        #1;
        check("bp_nothing_taken", 64'(results), 64'(rb + 1));
        check("bp_quiet",         out_valid,    0);

        // Back-to-back throughput
        s0 = pop_cyc.size();
        for (int i = 1; i <= 5; i++) send(vecs[i]);
        wait_results(rb + 6, "tp_results");
        for (int i = 1; i < 5; i++) begin
            if (pop_cyc.size() > s0 + i)
                check("tp_period", 64'(pop_cyc[s0 + i] - pop_cyc[s0 + i - 1]), 4);
        end

        n = 0;
        while (sweep_done < 4 && n < 60000) begin
            @(posedge clk);
            n++;
        end
        check("sweep_complete", 64'(sweep_done), 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
        localparam int NN = (gi == 0) ? 8 : (gi == 1) ? 8 : (gi == 2) ? 32 : 16;
        localparam int DD = (gi == 0) ? 1 : (gi == 1) ? 8 : (gi == 2) ? 8 : 4;

        logic          s_in_valid;
        logic          s_in_ready;
        logic [NN-1:0] s_x;
        logic [NN-1:0] s_y;
        logic          s_cin;
        logic          s_sub;
        logic          s_out_valid;
        logic          s_out_ready;
        logic [NN-1:0] s_sum;
        logic          s_carry;
        logic          s_ovf;

        adder_digit_serial #(.N(NN), .D(DD)) u_sweep_dut (
            .clk       (clk),
            .rst_n     (rst_sw_n),
            .in_valid  (s_in_valid),
            .in_ready  (s_in_ready),
            .X         (s_x),
            .Y         (s_y),
            .Cin       (s_cin),
            .sub       (s_sub),
            .out_valid (s_out_valid),
            .out_ready (s_out_ready),
            .sum       (s_sum),
            .carry     (s_carry),
            .overflow  (s_ovf)
        );

        initial begin
            longint        full;
            longint        half;
            longint        ux;
            longint        uy;
            longint        sx;
            longint        sy;
            longint        ci;
            longint        r;
            longint        rs;
            logic [NN-1:0] e_sum;
            logic          e_c;
            logic          e_v;
            int            lat;
            bit            ok;

            s_in_valid = 1'b0; s_x = '0; s_y = '0; s_cin = 1'b0; s_sub = 1'b0;
            s_out_ready = 1'b1;
            full = 64'sd1 <<< NN;
            half = full / 2;
            wait (rst_sw_n);
            @(posedge clk); #1;

            for (int t = 0; t < 1000; t++) begin
                s_x   = NN'({$urandom(), $urandom()});
                s_y   = NN'({$urandom(), $urandom()});
                s_cin = 1'($urandom());
                s_sub = 1'($urandom());
                s_in_valid = 1'b1;
                ok = 1'b0;
                for (int w = 0; w < 50 && !ok; w++) begin
                    @(negedge clk);
                    ok = s_in_ready;
                end
                @(posedge clk); #1;
                s_in_valid = 1'b0;
                lat = 0;
                while (!s_out_valid && lat < 100) begin
                    @(posedge clk); #1;
                    lat++;
                end

                ux = longint'(s_x);
                uy = longint'(s_y);
                sx = (ux >= half) ? ux - full : ux;
                sy = (uy >= half) ? uy - full : uy;
                ci = s_cin ? 64'sd1 : 64'sd0;
                if (s_sub) begin
                    r   = ux - uy - ci;
                    e_c = (r >= 0);
                    rs  = sx - sy - ci;
                end else begin
                    r   = ux + uy + ci;
                    e_c = (r >= full);
                    rs  = sx + sy + ci;
                end
                e_sum = NN'(r);
                e_v   = (rs >= half) || (rs < -half);

                check($sformatf("sweep%0d_latency", gi),  64'(lat), 64'(NN / DD));
                check($sformatf("sweep%0d_sum", gi),      s_sum,    e_sum);
                check($sformatf("sweep%0d_carry", gi),    s_carry,  e_c);
                check($sformatf("sweep%0d_overflow", gi), s_ovf,    e_v);
            end
            sweep_done++;
        end
    end

endmodule
`default_nettype wire

// File: doc/adder_digit_serial.md
# adder_digit_serial

Multi-cycle, parametrised successor to the combinational `adder_full_n`. It adds or subtracts two N-bit operands D bits per clock, LSB digit first, and keeps the inter-digit carry in a register. Operands enter and results leave on valid/ready handshakes, so the block can sit in datapaths where area matters more than latency. It also reports carry/borrow and signed overflow.

## Interface
- `N`, 32, operand width in bits.
- `D`, 8, digit width (bits added per cycle). N must be a multiple of D; 1 ≤ D ≤ N.
- `STAGES`, N/D, derived localparam, not overridable.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operands and mode are valid.
- `in_ready`  out  1  block can accept operands.
- `X`  in  N  operand A.
- `Y`  in  N  operand B.
- `Cin`  in  1  carry-in (add) or borrow-in (sub).
- `sub`  in  1  0 = X+Y+Cin; 1 = X−Y−Cin.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer takes the result.
- `sum`  out  N  result.
- `carry`  out  1  add: carry-out; sub: NOT borrow (1 = no borrow).
- `overflow`  out  1  two's-complement signed overflow.

## Operation
- FSM states: IDLE, BUSY, DONE.
- `in_ready` = (state == IDLE). `out_valid` = (state == DONE).
- IDLE → BUSY on `in_valid && in_ready`. At that edge:
  - capture X into `x_q`;
  - capture `Y_eff = sub ? ~Y : Y` into `y_q`;
  - set the carry register `c_q = Cin ^ sub`;
  - clear digit counter `k` to 0;
  - capture `sub`.
- BUSY, once per cycle:
  - `{c, s} = x_q[k*D +: D] + y_q[k*D +: D] + c_q`;
  - write `s` into the `sum_q` digit k, then `c_q <= c` and `k <= k+1`;
  - the edge that processes k = STAGES−1 moves the FSM to DONE and latches `carry = c` and `overflow = (x_msb == y_eff_msb) && (sum_msb != x_msb)`.
- DONE → IDLE on `out_ready`. `sum`, `carry` and `overflow` hold their values until the next accept overwrites them.
- While DONE and `out_ready` = 0, all outputs are stable. `in_valid` is ignored outside IDLE.
- Arithmetic is modulo 2^N, and `sum` width equals N. Subtraction borrow-in: Cin = 1 subtracts one extra.
- Reset (async, any state): state = IDLE, `in_ready` = 1, `out_valid` = 0, `sum` = 0, `carry` = 0, `overflow` = 0, `k` = 0, `c_q` = 0. Reset during BUSY discards the operation; no result is produced.

## Timing
- Latency: with the accept on edge E0, `out_valid` rises after edge E_STAGES.
- Minimum issue period is STAGES+2 cycles: the accept edge, STAGES compute edges, and the output handshake edge that returns to IDLE. Accept is then possible on the following edge.
- D = N gives STAGES = 1: a single BUSY cycle, `out_valid` after E1.
- `in_ready` and `out_valid` are decoded directly from state registers, with no combinational path from `in_valid` or `out_ready`.
- `sum`, `carry` and `overflow` are register outputs.

## Structure
- Package `adder_pkg`:
  - state enum `adder_state_t` {IDLE, BUSY, DONE};
  - a function that checks N % D == 0, elaborated as a fatal assertion.
- Sub-module: one instance of `adder_full_n #(.n(D))` serves as the digit adder (X, Y, Cin → sum, carry).
- Overflow is computed from sign bits, not from the internal MSB carry.
- Counter width: `$clog2(STAGES)`, minimum 1.

## Test plan
Directed benches use N = 8, D = 4 unless noted.
1. Assert `rst_n` low mid-BUSY, then release → `out_valid` = 0, `in_ready` = 1, `sum` = 0x00, `carry` = 0, `overflow` = 0; no result ever appears for the aborted operation.
2. Add 0xFF + 0x01, Cin = 0 → `sum` = 0x00, `carry` = 1, `overflow` = 0, with `out_valid` exactly 2 cycles after the accept edge. Then add 0x7F + 0x01 → `sum` = 0x80, `carry` = 0, `overflow` = 1.
3. Subtraction:
   - sub = 1, 0x05 − 0x07, Cin = 0 → `sum` = 0xFE, `carry` = 0, `overflow` = 0;
   - 0x80 − 0x01 → `sum` = 0x7F, `carry` = 1, `overflow` = 1;
   - 0x10 − 0x00 with Cin = 1 → `sum` = 0x0F, `carry` = 1.
4. Backpressure: hold `out_ready` = 0 for 5 cycles in DONE while pulsing `in_valid` → `sum`, `carry`, `overflow` and `out_valid` stay constant, `in_ready` = 0, nothing is accepted. Release → exactly one output handshake, then `in_ready` = 1 on the next cycle.
5. Throughput: keep `in_valid` and `out_ready` high continuously → one result every STAGES+2 = 4 cycles, in operand order.
6. Parameter sweep: (N, D) ∈ {(8,1), (8,8), (32,8), (16,4)} with 1000 random X, Y, Cin, sub values each → `sum`, `carry` and `overflow` match the reference model X ± Y ± Cin, and latency equals N/D.
